// File: rtl/vram_port_arbiter.sv
// VRAM port arbiter: time-shares the single VRAM address/write port between
// display scan-out reads and buffered CPU writes, with frame-latched mode select.
module vram_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int NMODE        = 2,
   parameter int MODE_W       = 1,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MODE_W-1:0]       mode_in,
   input  logic                    frame_start,
   input  logic                    disp_active,
   input  logic [NMODE*ADDR_W-1:0] disp_addr_bus,
   input  logic                    wr_req,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    wr_ready,
   output logic [MODE_W-1:0]       mode_q,
   output logic [ADDR_W-1:0]       vram_addr,
   output logic [DATA_W-1:0]       vram_din,
   output logic                    vram_we,
   output logic                    disp_valid,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT - 1);

   logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic [MODE_W-1:0] mode_d;
   logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
   logic [DATA_W-1:0] vram_din_q, vram_din_d;
   logic              vram_we_q, vram_we_d, disp_valid_q, disp_valid_d;
   logic              push_s, empty_s, steal_s, grant_wr_s, grant_disp_s;

   assign wr_ready   = (level_q < LVL_FULL);
   assign fifo_level = level_q;
   assign vram_addr  = vram_addr_q;
   assign vram_din   = vram_din_q;
   assign vram_we    = vram_we_q;
   assign disp_valid = disp_valid_q;

   // Arbitration, FIFO bookkeeping, starvation counter and mode latch next-state.
   always_comb begin
      push_s       = wr_req && wr_ready;
      empty_s      = (level_q == {LVL_W{1'b0}});
      steal_s      = (starve_q == CNT_MAX);
      grant_wr_s   = !empty_s && (!disp_active || steal_s);
      grant_disp_s = disp_active && !grant_wr_s;

      wr_ptr_d = push_s     ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = grant_wr_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      case ({push_s, grant_wr_s})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // The counter only runs while a write is blocked behind the display.
      if (grant_wr_s || empty_s) begin
         starve_d = {CNT_W{1'b0}};
      end else if (disp_active && (starve_q != CNT_MAX)) begin
         starve_d = starve_q + CNT_W'(1);
      end else begin
         starve_d = starve_q;
      end

      if (frame_start) begin
         if (int'(mode_in) < NMODE) begin
            mode_d = mode_in;
         end else begin
            mode_d = {MODE_W{1'b0}};
         end
      end else begin
         mode_d = mode_q;
      end

      vram_addr_d  = vram_addr_q;
      vram_din_d   = vram_din_q;
      vram_we_d    = 1'b0;
      disp_valid_d = 1'b0;
      if (grant_wr_s) begin
         vram_addr_d = fifo_addr_q[rd_ptr_q];
         vram_din_d  = fifo_data_q[rd_ptr_q];
         vram_we_d   = 1'b1;
      end else if (grant_disp_s) begin
         vram_addr_d  = disp_addr_bus[int'(mode_q)*ADDR_W +: ADDR_W];
         disp_valid_d = 1'b1;
      end else begin
         vram_we_d    = 1'b0;
         disp_valid_d = 1'b0;
      end
   end

   // Control state and registered VRAM port outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         level_q      <= {LVL_W{1'b0}};
         starve_q     <= {CNT_W{1'b0}};
         mode_q       <= {MODE_W{1'b0}};
         vram_addr_q  <= {ADDR_W{1'b0}};
         vram_din_q   <= {DATA_W{1'b0}};
         vram_we_q    <= 1'b0;
         disp_valid_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         starve_q     <= starve_d;
         mode_q       <= mode_d;
         vram_addr_q  <= vram_addr_d;
         vram_din_q   <= vram_din_d;
         vram_we_q    <= vram_we_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   // Write FIFO storage; contents are don't-care while the level says empty.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_q[wr_ptr_q] <= wr_addr;
         fifo_data_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: scoreboarded write ordering plus
// cycle-exact checks of mode latch, drain, full FIFO, starvation and reset.
module tb_vram_port_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  mode_in;
   logic        frame_start;
   logic        disp_active;
   logic [31:0] disp_addr_bus;
   logic        wr_req;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic [1:0]  mode_q;
   logic [15:0] vram_addr;
   logic [15:0] vram_din;
   logic        vram_we;
   logic        disp_valid;
   logic [2:0]  fifo_level;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   wr_t sb[$];
   int  vectors    = 0;
   int  miscompares = 0;

   vram_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .NMODE(2), .MODE_W(2), .DEPTH(4), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .rst(rst), .mode_in(mode_in), .frame_start(frame_start),
      .disp_active(disp_active), .disp_addr_bus(disp_addr_bus),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .mode_q(mode_q), .vram_addr(vram_addr), .vram_din(vram_din), .vram_we(vram_we),
      .disp_valid(disp_valid), .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_write(input logic [15:0] a, input logic [15:0] d, input bit accept);
      wr_req  = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (accept) sb.push_back('{a: a, d: d});
      tick();
      wr_req = 1'b0;
   endtask

   // Monitor: every VRAM write must match the next expected write in order.
   always @(negedge clk) begin
      if (!rst && vram_we) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr_order", {16'd0, vram_addr}, {16'd0, e.a});
            chk("wr_data_order", {16'd0, vram_din}, {16'd0, e.d});
         end
      end
   end

   initial begin
      rst           = 1'b1;
      mode_in       = 2'd0;
      frame_start   = 1'b0;
      disp_active   = 1'b0;
      disp_addr_bus = {16'hABCD, 16'h1234};
      wr_req        = 1'b0;
      wr_addr       = 16'd0;
      wr_data       = 16'd0;
      tick();
      tick();
      chk("rst_vram_addr", vram_addr, 32'd0);
      chk("rst_vram_din", vram_din, 32'd0);
      chk("rst_vram_we", vram_we, 32'd0);
      chk("rst_disp_valid", disp_valid, 32'd0);
      chk("rst_mode_q", mode_q, 32'd0);
      chk("rst_fifo_level", fifo_level, 32'd0);
      chk("rst_wr_ready", wr_ready, 32'd1);
      rst = 1'b0;

      // Mode switch: request without frame_start has no effect
      disp_active = 1'b1;
      mode_in     = 2'd1;
      tick();
      chk("mode_hold_addr", vram_addr, 32'h1234);
      chk("mode_hold_dv", disp_valid, 32'd1);
      chk("mode_hold_q", mode_q, 32'd0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("mode_latched", mode_q, 32'd1);
      chk("mode_old_addr", vram_addr, 32'h1234);
      tick();
      chk("mode_new_addr", vram_addr, 32'hABCD);
      mode_in     = 2'd3;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      mode_in     = 2'd0;
      chk("mode_invalid", mode_q, 32'd0);
      tick();
      chk("mode_invalid_addr", vram_addr, 32'h1234);

      // Blanking drain
      disp_active = 1'b0;
      tick();
      push_write(16'h0010, 16'hAAAA, 1'b1);
      chk("drain_no_we_yet", vram_we, 32'd0);
      push_write(16'h0011, 16'hBBBB, 1'b1);
      chk("drain_we1", vram_we, 32'd1);
      chk("drain_addr1", vram_addr, 32'h0010);
      chk("drain_din1", vram_din, 32'hAAAA);
      tick();
      chk("drain_we2", vram_we, 32'd1);
      chk("drain_addr2", vram_addr, 32'h0011);
      chk("drain_din2", vram_din, 32'hBBBB);
      chk("drain_level", fifo_level, 32'd0);
      tick();
      chk("drain_idle_we", vram_we, 32'd0);
      chk("drain_idle_dv", disp_valid, 32'd0);
      chk("drain_idle_addr_hold", vram_addr, 32'h0011);

      // Full FIFO while display owns the port
      disp_active = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_write(16'h0020 + 16'(i), 16'hC000 + 16'(i), 1'b1);
      end
      chk("full_level", fifo_level, 32'd4);
      chk("full_wr_ready", wr_ready, 32'd0);
      chk("full_no_we", vram_we, 32'd0);
      push_write(16'h0024, 16'hDEAD, 1'b0);
      chk("full_level_after5", fifo_level, 32'd4);
      chk("full_dv", disp_valid, 32'd1);
      disp_active = 1'b0;
      for (int i = 0; i < 20 && fifo_level != 3'd0; i++) tick();
      chk("full_drained", fifo_level, 32'd0);
      tick();
      tick();

      // Starvation: a single write steals exactly one display slot
      disp_active = 1'b1;
      tick();
      push_write(16'h0030, 16'h5555, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("starve_we_k%0d", k), vram_we, (k == 8) ? 32'd1 : 32'd0);
         chk($sformatf("starve_dv_k%0d", k), disp_valid, (k == 8) ? 32'd0 : 32'd1);
         if (k == 8) chk("starve_addr", vram_addr, 32'h0030);
         if (k == 9) chk("starve_resume_addr", vram_addr, 32'h1234);
      end

      // Reset mid-stream with queued writes
      mode_in     = 2'd1;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      mode_in     = 2'd0;
      chk("pre_rst_mode", mode_q, 32'd1);
      for (int i = 0; i < 3; i++) push_write(16'h0040 + 16'(i), 16'h7000 + 16'(i), 1'b0);
      chk("pre_rst_level", fifo_level, 32'd3);
      rst = 1'b1;
      #2;
      chk("mid_rst_addr", vram_addr, 32'd0);
      chk("mid_rst_din", vram_din, 32'd0);
      chk("mid_rst_we", vram_we, 32'd0);
      chk("mid_rst_dv", disp_valid, 32'd0);
      chk("mid_rst_mode", mode_q, 32'd0);
      chk("mid_rst_level", fifo_level, 32'd0);
      chk("mid_rst_wr_ready", wr_ready, 32'd1);
      tick();
      tick();
      rst         = 1'b0;
      disp_active = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_no_we", vram_we, 32'd0);
      end
      chk("post_rst_level", fifo_level, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
